// File: rtl/conv_read_input_controller.sv
// Read-side sequencer for the 3-row input buffer: walks (if, ky, kx) for one output tile
// and emits per-buffer read addresses, pad flags and row selects over a valid/ready stream.
module conv_read_input_controller #(
    parameter int PIXELS_IN_ROW          = 32,
    parameter int PIXELS_IN_ROW_IN_2POW  = 5,
    parameter int BUFFERS_NUM            = 3,
    parameter int IFS_IN_ROW_2POW        = 1,
    parameter int INPUT_BUFFER_SIZE_2POW = 12
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cfg_load,
    input  logic [3:0]  i_k_init,
    input  logic [3:0]  i_s_init,
    input  logic [3:0]  i_p_init,
    input  logic [15:0] i_ix_init,
    input  logic [15:0] i_iy_init,
    input  logic [15:0] i_nif_init,
    input  logic [3:0]  i_nif_in_2pow_init,
    input  logic [3:0]  i_ix_in_2pow_init,
    input  logic        i_tile_start,
    input  logic [15:0] i_ox_start,
    input  logic [15:0] i_oy_start,
    input  logic [15:0] i_pox,
    input  logic [15:0] i_poy,
    output logic        o_rd_valid,
    input  logic        i_rd_ready,
    output logic [15:0] o_buf_adr0,
    output logic [15:0] o_buf_adr1,
    output logic [15:0] o_buf_adr2,
    output logic [2:0]  o_buf_en,
    output logic [2:0]  o_buf_pad,
    output logic [1:0]  o_buf_row_sel0,
    output logic [1:0]  o_buf_row_sel1,
    output logic [1:0]  o_buf_row_sel2,
    output logic        o_word_select,
    output logic [4:0]  o_x_off,
    output logic [15:0] o_if_idx,
    output logic        o_step_last,
    output logic        o_tile_done,
    output logic        o_busy
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;
    localparam logic [1:0] M_HOLD = 2'd0, M_INC = 2'd1, M_INIT = 2'd2;

    state_t      r_state, w_state_next;
    logic [3:0]  r_k, r_s, r_p, r_nif2, r_ix2;
    logic [15:0] r_iy, r_nif, r_ox, r_oy, r_poy;
    logic [15:0] r_if, w_if_n, w_ifm1;
    logic [3:0]  r_ky, r_kx, w_ky_n, w_kx_n;
    logic [1:0]  w_mode;
    logic        w_accept, w_load, w_s_ok, w_unused;
    logic [7:0]  w_sh, w_mask_sh;
    logic [15:0] w_mask, w_oxm1, w_ixm1, w_col;

    logic [15:0] r_row_v [BUFFERS_NUM], w_row_v_n [BUFFERS_NUM], w_init_v [BUFFERS_NUM];
    logic [15:0] r_row_slot [BUFFERS_NUM], w_row_slot_n [BUFFERS_NUM], w_row_adr [BUFFERS_NUM];
    logic [1:0]  r_row_b [BUFFERS_NUM], w_row_b_n [BUFFERS_NUM];
    logic [17:0] w_div [BUFFERS_NUM];
    logic [BUFFERS_NUM-1:0] w_row_act, w_row_pad;

    logic [2:0]  r_en, r_pad, w_en_n, w_pad_n;
    logic [15:0] r_adr [BUFFERS_NUM], w_adr_n [BUFFERS_NUM];
    logic [1:0]  r_rs [BUFFERS_NUM], w_rs_n [BUFFERS_NUM];
    logic        r_rd_valid, r_busy, r_tile_done, r_step_last, r_word_select;
    logic [4:0]  r_x_off;

    // Restoring long division by 3: each stage is a bounded (<6) compare/subtract.
    function automatic logic [17:0] div3(input logic [17:0] u);
        logic [2:0]  rem;
        logic [17:0] q;
        rem = 3'd0;
        q   = 18'd0;
        for (int i = 17; i >= 0; i--) begin
            rem = {rem[1:0], u[i]};
            if (rem >= 3'd3) begin
                rem  = rem - 3'd3;
                q[i] = 1'b1;
            end
        end
        return {q[15:0], rem[1:0]};
    endfunction

    assign w_unused  = ^{i_pox, i_ix_init} ^ PIXELS_IN_ROW[0];
    assign w_accept  = (r_state == S_RUN) && r_rd_valid && i_rd_ready;
    assign w_load    = (r_state == S_SETUP) || (w_accept && !r_step_last);
    assign w_s_ok    = (r_s == 4'd1) || (r_s == 4'd2);
    assign w_ifm1    = w_if_n - 16'd1;
    assign w_sh      = 8'(r_nif2) + 8'(r_ix2) - 8'(IFS_IN_ROW_2POW) - 8'(PIXELS_IN_ROW_IN_2POW);
    assign w_mask_sh = 8'(16 - INPUT_BUFFER_SIZE_2POW) + w_sh;
    assign w_mask    = 16'hffff >> w_mask_sh;
    assign w_oxm1    = r_ox - 16'd1;
    assign w_ixm1    = (r_s == 4'd2) ? {w_oxm1[14:0], 1'b0} : w_oxm1;
    assign w_col     = (w_ixm1 << (r_nif2 - 4'(IFS_IN_ROW_2POW))) >> PIXELS_IN_ROW_IN_2POW;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_tile_start) w_state_next = S_SETUP;
            S_SETUP: w_state_next = S_RUN;
            S_RUN:   if (w_accept && r_step_last) w_state_next = S_DONE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Loop counters: kx innermost, then ky, then input feature.
    always_comb begin
        w_kx_n = r_kx;
        w_ky_n = r_ky;
        w_if_n = r_if;
        w_mode = M_HOLD;
        if (r_state == S_SETUP) begin
            w_kx_n = 4'd1;
            w_ky_n = 4'd1;
            w_if_n = 16'd1;
            w_mode = M_INIT;
        end else if (w_accept && !r_step_last) begin
            if (r_kx < r_k) begin
                w_kx_n = r_kx + 4'd1;
            end else if (r_ky < r_k) begin
                w_kx_n = 4'd1;
                w_ky_n = r_ky + 4'd1;
                w_mode = M_INC;
            end else begin
                w_kx_n = 4'd1;
                w_ky_n = 4'd1;
                w_if_n = r_if + 16'd1;
                w_mode = M_INIT;
            end
        end
    end

    // Per output row r: track iy-1, its buffer (mod 3) and slot (div 3) incrementally over ky.
    for (genvar gi = 0; gi < BUFFERS_NUM; gi++) begin : g_row
        logic [15:0] w_base;
        assign w_base       = r_oy - 16'd1 + 16'(gi);
        assign w_init_v[gi] = ((r_s == 4'd2) ? {w_base[14:0], 1'b0} : w_base) - {12'd0, r_p};
        // Offset by 48 (a multiple of 3) so small negative values still give a non-negative modulo.
        assign w_div[gi]    = div3({{2{w_init_v[gi][15]}}, w_init_v[gi]} + 18'd48);

        always_comb begin
            w_row_v_n[gi]    = r_row_v[gi];
            w_row_b_n[gi]    = r_row_b[gi];
            w_row_slot_n[gi] = r_row_slot[gi];
            if (w_mode == M_INIT) begin
                w_row_v_n[gi]    = w_init_v[gi];
                w_row_b_n[gi]    = w_div[gi][1:0];
                w_row_slot_n[gi] = w_div[gi][17:2] - 16'd16;
            end else if (w_mode == M_INC) begin
                w_row_v_n[gi]    = r_row_v[gi] + 16'd1;
                w_row_b_n[gi]    = (r_row_b[gi] == 2'd2) ? 2'd0 : r_row_b[gi] + 2'd1;
                w_row_slot_n[gi] = (r_row_b[gi] == 2'd2) ? r_row_slot[gi] + 16'd1 : r_row_slot[gi];
            end
        end

        assign w_row_act[gi] = w_s_ok && (r_poy > 16'(gi));
        assign w_row_pad[gi] = w_row_v_n[gi][15] || (w_row_v_n[gi] >= r_iy);
        assign w_row_adr[gi] = ((w_row_slot_n[gi] & w_mask) << w_sh) + w_col
                             + (w_ifm1 >> IFS_IN_ROW_2POW);

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_row_v[gi]    <= 16'd0;
                r_row_b[gi]    <= 2'd0;
                r_row_slot[gi] <= 16'd0;
            end else begin
                r_row_v[gi]    <= w_row_v_n[gi];
                r_row_b[gi]    <= w_row_b_n[gi];
                r_row_slot[gi] <= w_row_slot_n[gi];
            end
        end
    end

    always_comb begin
        w_en_n  = 3'b000;
        w_pad_n = 3'b000;
        for (int b = 0; b < BUFFERS_NUM; b++) begin
            w_adr_n[b] = 16'hffff;
            w_rs_n[b]  = 2'd0;
        end
        for (int r = 0; r < BUFFERS_NUM; r++) begin
            if (w_row_act[r]) begin
                if (w_row_pad[r]) begin
                    w_pad_n[w_row_b_n[r]] = 1'b1;
                end else begin
                    w_en_n[w_row_b_n[r]]  = 1'b1;
                    w_adr_n[w_row_b_n[r]] = w_row_adr[r];
                    w_rs_n[w_row_b_n[r]]  = 2'(r);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            {r_k, r_s, r_p, r_nif2, r_ix2} <= '0;
            {r_iy, r_nif, r_ox, r_oy, r_poy} <= '0;
            r_if <= 16'd1;
            r_ky <= 4'd1;
            r_kx <= 4'd1;
            r_rd_valid <= 1'b0;
            r_busy <= 1'b0;
            r_tile_done <= 1'b0;
            r_step_last <= 1'b0;
            r_word_select <= 1'b0;
            r_x_off <= 5'd0;
            r_en <= 3'b000;
            r_pad <= 3'b000;
            for (int b = 0; b < BUFFERS_NUM; b++) begin
                r_adr[b] <= 16'hffff;
                r_rs[b]  <= 2'd0;
            end
        end else begin
            if (r_state == S_IDLE && i_cfg_load) begin
                r_k <= i_k_init;
                r_s <= i_s_init;
                r_p <= i_p_init;
                r_iy <= i_iy_init;
                r_nif <= i_nif_init;
                r_nif2 <= i_nif_in_2pow_init;
                r_ix2 <= i_ix_in_2pow_init;
            end
            if (r_state == S_IDLE && i_tile_start) begin
                r_ox <= i_ox_start;
                r_oy <= i_oy_start;
                r_poy <= i_poy;
            end
            r_if <= w_if_n;
            r_ky <= w_ky_n;
            r_kx <= w_kx_n;
            r_rd_valid  <= (w_state_next == S_RUN);
            r_busy      <= (w_state_next != S_IDLE);
            r_tile_done <= (w_state_next == S_DONE);
            if (w_load) begin
                r_en <= w_en_n;
                r_pad <= w_pad_n;
                r_adr <= w_adr_n;
                r_rs <= w_rs_n;
                r_word_select <= w_ifm1[0];
                r_x_off <= {1'b0, w_kx_n} - 5'd1 - {1'b0, r_p};
                r_step_last <= (w_kx_n == r_k) && (w_ky_n == r_k) && (w_if_n == r_nif);
            end
        end
    end

    assign o_rd_valid     = r_rd_valid;
    assign o_busy         = r_busy;
    assign o_tile_done    = r_tile_done;
    assign o_step_last    = r_step_last;
    assign o_buf_en       = r_en;
    assign o_buf_pad      = r_pad;
    assign o_buf_adr0     = r_adr[0];
    assign o_buf_adr1     = r_adr[1];
    assign o_buf_adr2     = r_adr[2];
    assign o_buf_row_sel0 = r_rs[0];
    assign o_buf_row_sel1 = r_rs[1];
    assign o_buf_row_sel2 = r_rs[2];
    assign o_word_select  = r_word_select;
    assign o_x_off        = r_x_off;
    assign o_if_idx       = r_if;
endmodule
